// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes on both sides. Single-cycle ops
// are computed from latched operands one cycle after accept; MUL (shift-add)
// and DIV (restoring) iterate WIDTH cycles in a shared 2*WIDTH accumulator.
module alu_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           opcode,
  input  logic [WIDTH-1:0]     operand1,
  input  logic [WIDTH-1:0]     operand2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 flagC,
  output logic                 flagZ
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpMul  = 4'd2;
  localparam logic [3:0] OpDiv  = 4'd3;
  localparam logic [3:0] OpAnd  = 4'd4;
  localparam logic [3:0] OpOr   = 4'd5;
  localparam logic [3:0] OpXor  = 4'd6;
  localparam logic [3:0] OpNot  = 4'd7;
  localparam logic [3:0] OpShl  = 4'd8;
  localparam logic [3:0] OpShr  = 4'd9;
  localparam logic [3:0] OpRol  = 4'd10;
  localparam logic [3:0] OpRor  = 4'd11;
  localparam logic [3:0] OpInc  = 4'd12;
  localparam logic [3:0] OpDec  = 4'd13;
  localparam logic [3:0] OpCmp  = 4'd14;
  localparam logic [3:0] OpPass = 4'd15;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(WIDTH);

  logic [1:0]           state_q,  state_d;
  logic [3:0]           op_q,     op_d;
  logic [WIDTH-1:0]     a_q,      a_d;
  logic [WIDTH-1:0]     b_q,      b_d;
  logic [2*WIDTH-1:0]   acc_q,    acc_d;
  logic [CNT_W-1:0]     cnt_q,    cnt_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 flag_c_q, flag_c_d;
  logic                 flag_z_q, flag_z_d;

  logic                 iterative;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_shift;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_diff;
  logic [WIDTH-1:0]     div_rem;
  logic [2*WIDTH-1:0]   div_next;
  logic [WIDTH:0]       add_sum;
  logic [WIDTH:0]       sub_diff;
  logic [WIDTH:0]       inc_sum;
  logic [WIDTH-1:0]     dec_val;
  logic [WIDTH-1:0]     res_hi;
  logic [WIDTH-1:0]     res_lo;
  logic [2*WIDTH-1:0]   alu_res;
  logic                 alu_c;
  logic                 alu_z;

  // Divide-by-zero short-circuits the iteration and finishes like a single-cycle op.
  assign iterative = (op_q == OpMul) || ((op_q == OpDiv) && (b_q != '0));

  // Shift-add step: acc holds {partial product, remaining multiplier bits}, LSB first.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring step: acc holds {remainder, dividend bits shifting into quotient}.
  // The trial difference fits WIDTH bits whenever it is kept (remainder < divisor).
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, b_q};
  assign div_diff  = div_shift[WIDTH-1:0] - b_q;
  assign div_rem   = div_ge ? div_diff : div_shift[WIDTH-1:0];
  assign div_next  = {div_rem, acc_q[WIDTH-2:0], div_ge};

  assign add_sum  = {1'b0, a_q} + {1'b0, b_q};
  assign sub_diff = {1'b0, a_q} - {1'b0, b_q};
  assign inc_sum  = {1'b0, a_q} + (WIDTH+1)'(1);
  assign dec_val  = a_q - WIDTH'(1);

  // Final result and flags from latched operands (or the finished accumulator).
  always_comb begin
    res_hi = '0;
    res_lo = '0;
    alu_c  = 1'b0;
    unique case (op_q)
      OpAdd:  begin res_lo = add_sum[WIDTH-1:0];  alu_c = add_sum[WIDTH];  end
      OpSub:  begin res_lo = sub_diff[WIDTH-1:0]; alu_c = sub_diff[WIDTH]; end
      OpMul:  begin res_hi = acc_q[2*WIDTH-1:WIDTH]; res_lo = acc_q[WIDTH-1:0]; end
      OpDiv: begin
        if (b_q == '0) begin
          res_hi = '1;
          res_lo = '1;
          alu_c  = 1'b1;
        end else begin
          res_hi = acc_q[2*WIDTH-1:WIDTH];
          res_lo = acc_q[WIDTH-1:0];
        end
      end
      OpAnd:  res_lo = a_q & b_q;
      OpOr:   res_lo = a_q | b_q;
      OpXor:  res_lo = a_q ^ b_q;
      OpNot:  res_lo = ~a_q;
      OpShl:  begin res_lo = {a_q[WIDTH-2:0], 1'b0};       alu_c = a_q[WIDTH-1]; end
      OpShr:  begin res_lo = {1'b0, a_q[WIDTH-1:1]};       alu_c = a_q[0];       end
      OpRol:  begin res_lo = {a_q[WIDTH-2:0], a_q[WIDTH-1]}; alu_c = a_q[WIDTH-1]; end
      OpRor:  begin res_lo = {a_q[0], a_q[WIDTH-1:1]};     alu_c = a_q[0];       end
      OpInc:  begin res_lo = inc_sum[WIDTH-1:0]; alu_c = inc_sum[WIDTH]; end
      OpDec:  begin res_lo = dec_val;            alu_c = (a_q == '0);    end
      OpCmp:  alu_c = (a_q < b_q);
      OpPass: res_lo = b_q;
      default: ;
    endcase
    alu_res = {res_hi, res_lo};
    alu_z   = (op_q == OpCmp) ? (a_q == b_q) : (alu_res == '0);
  end

  // Next-state: accept in IDLE, iterate or finish in BUSY, hold in DONE until drained.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    flag_c_d = flag_c_q;
    flag_z_d = flag_z_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_d    = opcode;
          a_d     = operand1;
          b_d     = operand2;
          cnt_d   = '0;
          acc_d   = (opcode == OpDiv) ? {{WIDTH{1'b0}}, operand1} : {{WIDTH{1'b0}}, operand2};
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (iterative && (cnt_q != CntLast)) begin
          cnt_d = cnt_q + CNT_W'(1);
          acc_d = (op_q == OpMul) ? mul_next : div_next;
        end else begin
          result_d = alu_res;
          flag_c_d = alu_c;
          flag_z_d = alu_z;
          state_d  = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset; reset drops any in-flight op.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      flag_c_q <= flag_c_d;
      flag_z_q <= flag_z_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign flagC     = flag_c_q;
  assign flagZ     = flag_z_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed, table-driven bench for alu_seq at WIDTH=8.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  opcode;
  logic [7:0]  operand1;
  logic [7:0]  operand2;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        flagC;
  logic        flagZ;

  int errors = 0;
  int checks = 0;

  alu_seq #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .opcode   (opcode),
    .operand1 (operand1),
    .operand2 (operand2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .flagC    (flagC),
    .flagZ    (flagZ)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    logic        c;
    logic        z;
    int          lat;
  } vec_t;

  localparam int NVec = 31;
  vec_t vecs [NVec];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, " in_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic accept(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    opcode   = op;
    operand1 = a;
    operand2 = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Scramble operands after accept; the DUT must have latched them.
    operand1 = ~a;
    operand2 = ~b;
    opcode   = ~op;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (lat < 40 && !out_valid) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic drain();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int lat;
    wait_ready(name);
    accept(v.op, v.a, v.b);
    wait_out(lat);
    chk({name, " latency"}, 32'(lat), 32'(v.lat));
    chk({name, " result"}, 32'(result), 32'(v.res));
    chk({name, " flagC"}, 32'(flagC), 32'(v.c));
    chk({name, " flagZ"}, 32'(flagZ), 32'(v.z));
    chk({name, " in_ready in DONE"}, 32'(in_ready), 32'd0);
    drain();
    chk({name, " out_valid after drain"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int lat;
    int hits;

    vecs[0]  = '{4'd0,  8'hAA, 8'h55, 16'h00FF, 1'b0, 1'b0, 1};
    vecs[1]  = '{4'd1,  8'h55, 8'hAA, 16'h00AB, 1'b1, 1'b0, 1};
    vecs[2]  = '{4'd0,  8'hFF, 8'h01, 16'h0000, 1'b1, 1'b1, 1};
    vecs[3]  = '{4'd2,  8'hAA, 8'h55, 16'h3872, 1'b0, 1'b0, 9};
    vecs[4]  = '{4'd2,  8'hFF, 8'hFF, 16'hFE01, 1'b0, 1'b0, 9};
    vecs[5]  = '{4'd3,  8'hAA, 8'h55, 16'h0002, 1'b0, 1'b0, 9};
    vecs[6]  = '{4'd3,  8'h64, 8'h07, 16'h020E, 1'b0, 1'b0, 9};
    vecs[7]  = '{4'd3,  8'h12, 8'h00, 16'hFFFF, 1'b1, 1'b0, 1};
    // Opcode sweep with 0xAA / 0x55
    vecs[8]  = '{4'd0,  8'hAA, 8'h55, 16'h00FF, 1'b0, 1'b0, 1};
    vecs[9]  = '{4'd1,  8'hAA, 8'h55, 16'h0055, 1'b0, 1'b0, 1};
    vecs[10] = '{4'd2,  8'hAA, 8'h55, 16'h3872, 1'b0, 1'b0, 9};
    vecs[11] = '{4'd3,  8'hAA, 8'h55, 16'h0002, 1'b0, 1'b0, 9};
    vecs[12] = '{4'd4,  8'hAA, 8'h55, 16'h0000, 1'b0, 1'b1, 1};
    vecs[13] = '{4'd5,  8'hAA, 8'h55, 16'h00FF, 1'b0, 1'b0, 1};
    vecs[14] = '{4'd6,  8'hAA, 8'h55, 16'h00FF, 1'b0, 1'b0, 1};
    vecs[15] = '{4'd7,  8'hAA, 8'h55, 16'h0055, 1'b0, 1'b0, 1};
    vecs[16] = '{4'd8,  8'hAA, 8'h55, 16'h0054, 1'b1, 1'b0, 1};
    vecs[17] = '{4'd9,  8'hAA, 8'h55, 16'h0055, 1'b0, 1'b0, 1};
    vecs[18] = '{4'd10, 8'hAA, 8'h55, 16'h0055, 1'b1, 1'b0, 1};
    vecs[19] = '{4'd11, 8'hAA, 8'h55, 16'h0055, 1'b0, 1'b0, 1};
    vecs[20] = '{4'd12, 8'hAA, 8'h55, 16'h00AB, 1'b0, 1'b0, 1};
    vecs[21] = '{4'd13, 8'hAA, 8'h55, 16'h00A9, 1'b0, 1'b0, 1};
    vecs[22] = '{4'd14, 8'hAA, 8'h55, 16'h0000, 1'b0, 1'b0, 1};
    vecs[23] = '{4'd15, 8'hAA, 8'h55, 16'h0055, 1'b0, 1'b0, 1};
    // Boundary cases
    vecs[24] = '{4'd12, 8'hFF, 8'h00, 16'h0000, 1'b1, 1'b1, 1};
    vecs[25] = '{4'd13, 8'h00, 8'h00, 16'h00FF, 1'b1, 1'b0, 1};
    vecs[26] = '{4'd14, 8'h33, 8'h33, 16'h0000, 1'b0, 1'b1, 1};
    vecs[27] = '{4'd14, 8'h10, 8'h20, 16'h0000, 1'b1, 1'b0, 1};
    vecs[28] = '{4'd2,  8'h00, 8'h37, 16'h0000, 1'b0, 1'b1, 9};
    vecs[29] = '{4'd3,  8'h07, 8'h09, 16'h0700, 1'b0, 1'b0, 9};
    vecs[30] = '{4'd9,  8'h01, 8'h00, 16'h0000, 1'b1, 1'b1, 1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    opcode    = 4'd0;
    operand1  = 8'h00;
    operand2  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset result", 32'(result), 32'd0);
    chk("reset flagC", 32'(flagC), 32'd0);
    chk("reset flagZ", 32'(flagZ), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NVec; i++) begin
      run_vec($sformatf("vec%0d op%0d", i, vecs[i].op), vecs[i]);
    end

    // Backpressure: DONE holds with stable outputs and ignores new requests.
    wait_ready("bp");
    accept(4'd0, 8'h12, 8'h34);
    wait_out(lat);
    chk("bp latency", 32'(lat), 32'd1);
    @(negedge clk);
    in_valid = 1'b1;
    opcode   = 4'd1;
    operand1 = 8'h01;
    operand2 = 8'h02;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp hold%0d out_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("bp hold%0d in_ready", k), 32'(in_ready), 32'd0);
      chk($sformatf("bp hold%0d result", k), 32'(result), 32'h0046);
      chk($sformatf("bp hold%0d flags", k), 32'({flagC, flagZ}), 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    drain();
    chk("bp after drain in_ready", 32'(in_ready), 32'd1);
    hits = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (out_valid) hits++;
    end
    chk("bp no ghost accept", 32'(hits), 32'd0);

    // Reset in the middle of a MUL: no result may appear afterwards.
    wait_ready("rst");
    accept(4'd2, 8'hAA, 8'h55);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst mid-mul in_ready", 32'(in_ready), 32'd1);
    chk("rst mid-mul out_valid", 32'(out_valid), 32'd0);
    chk("rst mid-mul result", 32'(result), 32'd0);
    chk("rst mid-mul flags", 32'({flagC, flagZ}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    hits = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (out_valid) hits++;
    end
    chk("rst mid-mul no stale output", 32'(hits), 32'd0);
    run_vec("post-rst add", vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
